mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Shares one memory bus between the core's instruction-fetch port and data-access (MEM stage) port. Only one transaction is outstanding at a time, and the requester is held in a stall until its response returns. Data accesses have priority, but a starvation counter guarantees fetch progress. A pending fetch can be killed on a taken branch or jump without breaking the bus protocol.

Parameters:
MAX_DATA_STREAK, 4, consecutive data grants allowed while inst_req is pending before fetch is forced to win (range 1..15).
XLEN, 32, address and data width.

Ports:
clk  input  1  core clock
reset_n  input  1  asynchronous active-low reset
inst_req  input  1  fetch request; held until inst_valid
inst_addr  input  XLEN  fetch address (current_pc_if)
inst_kill  input  1  discard in-flight fetch (pc_sel_mem)
inst_rdata  output  XLEN  fetched instruction, valid with inst_valid
inst_valid  output  1  one-cycle fetch completion pulse
inst_stall  output  1  inst_req & ~inst_valid
data_req  input  1  load/store request; held until data_valid
data_we  input  1  1 = store
data_addr  input  XLEN  byte address
data_wdata  input  XLEN  store data
data_op  input  3  fun3 size/sign code, passed through
data_rdata  output  XLEN  load data
data_valid  output  1  one-cycle data completion pulse (loads and stores)
data_stall  output  1  data_req & ~data_valid
bus_req  output  1  bus request; held until bus_gnt
bus_we  output  1  write enable
bus_addr  output  XLEN  address
bus_wdata  output  XLEN  write data
bus_op  output  3  size code (3'b010 for fetch)
bus_gnt  input  1  bus accepted request this cycle
bus_rvalid  input  1  response/ack; only sampled in WAIT_RSP
bus_rdata  input  XLEN  read data

Behaviour:
- Reset (async, any state): state=IDLE; all bus_* outputs, inst_valid, data_valid, rdata outputs, owner, killed flag and streak counter are 0. Stalls follow their combinational equations.
- FSM states: IDLE, ISSUE, WAIT_RSP, RESP.
- IDLE:
  - If any request is pending, arbitrate and latch owner plus payload (addr/we/wdata/op) into registers, then go to ISSUE.
  - Priority: data wins unless inst_req=1 and streak==MAX_DATA_STREAK, in which case inst wins.
  - A fetch latches we=0, wdata=0, op=3'b010.
- ISSUE:
  - bus_req=1; bus_* driven from the latched payload, stable until bus_gnt.
  - On bus_gnt, go to WAIT_RSP. bus_req must never drop before gnt, even on kill.
- WAIT_RSP:
  - bus_req=0.
  - On bus_rvalid, register bus_rdata into the owner's rdata and go to RESP.
  - bus_rvalid is ignored in every other state.
- RESP:
  - The owner's valid is 1 for exactly this cycle; no arbitration is performed.
  - Next state is IDLE. The requester either drops its req or presents a new one at that point.
- Minimum latency: req seen in cycle 0, bus_req in cycle 1 (gnt same cycle), rvalid in cycle 2, valid in cycle 3. Peak rate is 1 transaction per 4 cycles.
- Streak counter:
  - Increments on each data grant (IDLE→ISSUE, owner=data) while inst_req=1.
  - Cleared on any inst grant, or on any IDLE cycle with inst_req=0.
  - Saturates at MAX_DATA_STREAK.
- Kill:
  - inst_kill while owner=inst in ISSUE, WAIT_RSP or RESP sets killed.
  - A killed transaction completes normally on the bus, but inst_valid stays 0 and inst_rdata is not updated.
  - killed is cleared when the FSM enters IDLE.
  - inst_kill in IDLE, or while owner=data, has no effect.
  - inst_kill in the same cycle as bus_rvalid still suppresses the response.
- Writes complete with the bus_rvalid ack; data_rdata is unchanged for writes.
- Simultaneous inst_req and data_req in IDLE resolve per the priority rule; the loser stays stalled.

Decomposition:
- Shared core package:
  - arb_state_t enum {IDLE, ISSUE, WAIT_RSP, RESP}
  - arb_owner_t enum {OWN_INST, OWN_DATA}
  - bus_req_t packed struct {we, addr, wdata, op}
  - constant FETCH_OP=3'b010
- Payload latch: the existing n_bit_reg_wclr, sized $bits(bus_req_t).
- Natural sub-module: arb_streak_ctr (saturating counter with clear and a sat flag output).

Test Plan:
- Single fetch: inst_req=1, addr=0x100, gnt in cycle 1, rvalid in cycle 2 with rdata=0x00500093 → inst_valid pulse in cycle 3 with inst_rdata=0x00500093; inst_stall=1 in cycles 0–2 and 0 in cycle 3.
- Contention: inst_req and data_req (load, addr 0x2000) asserted together → bus_addr=0x2000 first, fetch issued in the following IDLE; data_valid precedes inst_valid.
- Starvation: inst_req held high with data_req continuously re-asserted, MAX_DATA_STREAK=4 → exactly 4 data grants, then a fetch grant, after which the streak counter reads 0.
- Gnt backpressure plus kill: fetch in ISSUE, bus_gnt low for 3 cycles, inst_kill pulsed in the 2nd → bus_req/addr stable all 3 cycles, transaction completes on the bus, inst_valid never asserts, the next fetch issues normally.
- Store: data_we=1, addr=0x3000, wdata=0xDEADBEEF, op=3'b010 → bus_we=1 with matching payload; on ack, data_valid pulses and data_rdata is unchanged.
- Reset mid-operation: reset_n low during WAIT_RSP → all outputs 0 immediately; after release, a stray bus_rvalid is ignored and a fresh request starts from IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared types and constants for the instruction/data memory bus arbiter
package mem_bus_arbiter_pkg;

    localparam int BUS_XLEN = 32;
    localparam logic [2:0] FETCH_OP = 3'b010;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} arb_state_t;

    typedef enum logic {OWN_INST, OWN_DATA} arb_owner_t;

    typedef struct packed {
        logic                we;
        logic [BUS_XLEN-1:0] addr;
        logic [BUS_XLEN-1:0] wdata;
        logic [2:0]          op;
    } bus_req_t;

endpackage

// File: rtl/arb_streak_ctr.sv
// arb_streak_ctr: saturating count of consecutive data grants made while a fetch waits
module arb_streak_ctr #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [3:0] count;

    assign sat = count == 4'(MAX);

    // count up to MAX and hold there; clear has priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && !sat)
            count <= count + 4'd1;
    end

endmodule

// File: rtl/n_bit_reg_wclr.sv
// n_bit_reg_wclr: N-bit register with write enable and synchronous clear
module n_bit_reg_wclr #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wen,
    input  logic         clr,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // clear wins over load so a stale value never survives a clear request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (wen)
            q <= d;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between fetch and data ports, one transaction at a time
module mem_bus_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int XLEN            = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            inst_req,
    input  logic [XLEN-1:0] inst_addr,
    input  logic            inst_kill,
    output logic [XLEN-1:0] inst_rdata,
    output logic            inst_valid,
    output logic            inst_stall,
    input  logic            data_req,
    input  logic            data_we,
    input  logic [XLEN-1:0] data_addr,
    input  logic [XLEN-1:0] data_wdata,
    input  logic [2:0]      data_op,
    output logic [XLEN-1:0] data_rdata,
    output logic            data_valid,
    output logic            data_stall,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [2:0]      bus_op,
    input  logic            bus_gnt,
    input  logic            bus_rvalid,
    input  logic [XLEN-1:0] bus_rdata
);

    import mem_bus_arbiter_pkg::*;

    arb_state_t state, state_nx;
    arb_owner_t owner;
    bus_req_t   pay, pay_d;
    logic       killed;
    logic       streak_sat;
    logic       any_req, grant_inst, start, rsp;

    assign any_req    = inst_req | data_req;
    assign grant_inst = inst_req & (~data_req | streak_sat);
    assign start      = (state == IDLE) & any_req;
    assign rsp        = (state == WAIT_RSP) & bus_rvalid;
    assign pay_d      = grant_inst ? {1'b0, inst_addr, {XLEN{1'b0}}, FETCH_OP}
                                   : {data_we, data_addr, data_wdata, data_op};

    n_bit_reg_wclr #(.N($bits(bus_req_t))) u_pay (
        .clk     (clk),
        .reset_n (reset_n),
        .wen     (start),
        .clr     (state == RESP),
        .d       (pay_d),
        .q       (pay)
    );

    arb_streak_ctr #(.MAX(MAX_DATA_STREAK)) u_streak (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (start & ~grant_inst & inst_req),
        .clr     ((state == IDLE) & (~inst_req | grant_inst)),
        .sat     (streak_sat)
    );

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next state: one request is issued, granted, answered and reported in turn
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = any_req ? ISSUE : IDLE;
            ISSUE:    state_nx = bus_gnt ? WAIT_RSP : ISSUE;
            WAIT_RSP: state_nx = bus_rvalid ? RESP : WAIT_RSP;
            RESP:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // owner is latched at arbitration; killed marks an in-flight fetch whose result must be dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner  <= OWN_INST;
            killed <= 1'b0;
        end else begin
            if (start)
                owner <= grant_inst ? OWN_INST : OWN_DATA;
            if (state == RESP)
                killed <= 1'b0;
            else if (state != IDLE && owner == OWN_INST && inst_kill)
                killed <= 1'b1;
        end
    end

    // capture read data for the owner; killed fetches and stores leave their rdata untouched
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            if (rsp && owner == OWN_INST && !killed && !inst_kill)
                inst_rdata <= bus_rdata;
            if (rsp && owner == OWN_DATA && !pay.we)
                data_rdata <= bus_rdata;
        end
    end

    assign inst_valid = (state == RESP) & (owner == OWN_INST) & ~killed & ~inst_kill;
    assign data_valid = (state == RESP) & (owner == OWN_DATA);
    assign inst_stall = inst_req & ~inst_valid;
    assign data_stall = data_req & ~data_valid;

    assign bus_req   = state == ISSUE;
    assign bus_we    = bus_req & pay.we;
    assign bus_addr  = bus_req ? pay.addr : '0;
    assign bus_wdata = bus_req ? pay.wdata : '0;
    assign bus_op    = bus_req ? pay.op : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_bus_arbiter;

    localparam int MAXS = 4;

    logic        clk, reset_n;
    logic        inst_req, inst_kill, data_req, data_we;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic [2:0]  data_op;
    logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata, bus_rdata;
    logic        inst_valid, inst_stall, data_valid, data_stall;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [2:0]  bus_op;

    int          vectors = 0;
    int          miscompares = 0;

    int          gnt_pct = 100;
    int          rv_pct = 100;
    bit          rd_fix_en = 1'b1;
    logic [31:0] rd_fix = 32'h0050_0093;

    mem_bus_arbiter #(.MAX_DATA_STREAK(MAXS), .XLEN(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_kill  (inst_kill),
        .inst_rdata (inst_rdata),
        .inst_valid (inst_valid),
        .inst_stall (inst_stall),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_op    (data_op),
        .data_rdata (data_rdata),
        .data_valid (data_valid),
        .data_stall (data_stall),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_op     (bus_op),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // bus slave: random grant/response, stray responses allowed in any state
    initial begin
        bus_gnt = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            bus_gnt = $urandom_range(99) < gnt_pct;
            bus_rvalid = $urandom_range(99) < rv_pct;
            bus_rdata = rd_fix_en ? rd_fix : $urandom;
        end
    end

    // transaction-level model: a single outstanding transaction record
    bit          t_on, t_gnt, t_ans, t_inst, t_kill, p_we;
    logic [31:0] p_addr, p_wdata, e_irdata, e_drdata;
    logic [2:0]  p_op;
    int          m_streak;

    always @(negedge clk) begin
        bit e_breq, e_resp, e_iv, e_dv, give_inst;
        if (!reset_n) begin
            t_on = 0; t_gnt = 0; t_ans = 0; t_inst = 0; t_kill = 0;
            e_irdata = 0; e_drdata = 0; m_streak = 0;
        end
        e_breq = t_on && !t_gnt;
        e_resp = t_on && t_ans;
        e_iv = e_resp && t_inst && !t_kill && !inst_kill;
        e_dv = e_resp && !t_inst;
        chk("m_bus_req", 32'(bus_req), 32'(e_breq));
        chk("m_inst_valid", 32'(inst_valid), 32'(e_iv));
        chk("m_data_valid", 32'(data_valid), 32'(e_dv));
        chk("m_inst_stall", 32'(inst_stall), 32'(inst_req && !e_iv));
        chk("m_data_stall", 32'(data_stall), 32'(data_req && !e_dv));
        chk("m_inst_rdata", inst_rdata, e_irdata);
        chk("m_data_rdata", data_rdata, e_drdata);
        if (e_breq) begin
            chk("m_bus_we", 32'(bus_we), 32'(p_we));
            chk("m_bus_addr", bus_addr, p_addr);
            chk("m_bus_wdata", bus_wdata, p_wdata);
            chk("m_bus_op", 32'(bus_op), 32'(p_op));
        end
        if (reset_n) begin
            if (t_on && t_inst && inst_kill) t_kill = 1;
            if (!t_on) begin
                if (inst_req || data_req) begin
                    give_inst = inst_req && (!data_req || m_streak >= MAXS);
                    t_on = 1; t_gnt = 0; t_ans = 0; t_kill = 0; t_inst = give_inst;
                    if (give_inst) begin
                        p_we = 0; p_addr = inst_addr; p_wdata = 0; p_op = 3'b010;
                    end else begin
                        p_we = data_we; p_addr = data_addr; p_wdata = data_wdata; p_op = data_op;
                    end
                    m_streak = give_inst ? 0 : (inst_req ? m_streak + 1 : 0);
                end else begin
                    m_streak = 0;
                end
            end else if (!t_gnt) begin
                t_gnt = bus_gnt;
            end else if (!t_ans) begin
                if (bus_rvalid) begin
                    t_ans = 1;
                    if (t_inst && !t_kill) e_irdata = bus_rdata;
                    if (!t_inst && !p_we) e_drdata = bus_rdata;
                end
            end else begin
                t_on = 0;
                t_kill = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    initial begin
        int  ndata;
        bit  found, iv, dv;
        reset_n = 1'b0;
        inst_req = 0; inst_kill = 0; inst_addr = 0;
        data_req = 0; data_we = 0; data_addr = 0; data_wdata = 0; data_op = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        samp();
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_valids", 32'({inst_valid, data_valid}), 0);
        chk("rst_inst_rdata", inst_rdata, 0);
        chk("rst_data_rdata", data_rdata, 0);

        // single fetch at minimum latency
        tick(); inst_req = 1; inst_addr = 32'h100;
        samp(); chk("sf_c0_stall", 32'(inst_stall), 1); chk("sf_c0_breq", 32'(bus_req), 0);
        tick(); samp();
        chk("sf_c1_breq", 32'(bus_req), 1); chk("sf_c1_addr", bus_addr, 32'h100);
        chk("sf_c1_op", 32'(bus_op), 2); chk("sf_c1_stall", 32'(inst_stall), 1);
        tick(); samp(); chk("sf_c2_breq", 32'(bus_req), 0); chk("sf_c2_stall", 32'(inst_stall), 1);
        tick(); samp();
        chk("sf_c3_valid", 32'(inst_valid), 1); chk("sf_c3_rdata", inst_rdata, 32'h0050_0093);
        chk("sf_c3_stall", 32'(inst_stall), 0);
        tick(); inst_req = 0;

        // contention: data first, then fetch
        inst_req = 1; inst_addr = 32'h200; data_req = 1; data_we = 0; data_addr = 32'h2000; data_op = 3'b100;
        samp();
        tick(); samp(); chk("ct_first_addr", bus_addr, 32'h2000); chk("ct_first_we", 32'(bus_we), 0);
        tick(); tick(); samp(); chk("ct_dvalid", 32'(data_valid), 1); chk("ct_ivalid_early", 32'(inst_valid), 0);
        tick(); data_req = 0;
        tick(); samp(); chk("ct_second_addr", bus_addr, 32'h200);
        tick(); tick(); samp(); chk("ct_ivalid", 32'(inst_valid), 1);
        tick(); inst_req = 0;

        // starvation: fetch wins after MAXS data grants
        inst_req = 1; inst_addr = 32'h204; data_req = 1; data_addr = 32'h2004;
        ndata = 0; found = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            samp();
            if (bus_req && bus_gnt) begin
                if (bus_addr == 32'h204) begin
                    found = 1;
                    chk("sv_streak_cleared", 32'(dut.u_streak.count), 0);
                end else ndata++;
            end
        end
        chk("sv_fetch_granted", 32'(found), 1);
        chk("sv_data_grants", 32'(ndata), 32'(MAXS));
        tick(); data_req = 0;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            samp();
            found = inst_valid;
        end
        chk("sv_fetch_done", 32'(found), 1);
        tick(); inst_req = 0;

        // grant backpressure with a kill in the second stalled cycle
        gnt_pct = 0; rd_fix = 32'hBAD0_BAD0;
        tick(); inst_req = 1; inst_addr = 32'h400;
        samp();
        tick(); samp(); chk("bp_c1_breq", 32'(bus_req), 1); chk("bp_c1_addr", bus_addr, 32'h400);
        tick(); inst_kill = 1; inst_addr = 32'h500;
        samp(); chk("bp_c2_breq", 32'(bus_req), 1); chk("bp_c2_addr", bus_addr, 32'h400);
        tick(); inst_kill = 0;
        samp(); chk("bp_c3_breq", 32'(bus_req), 1); chk("bp_c3_addr", bus_addr, 32'h400);
        tick(); gnt_pct = 100;
        tick(); tick(); samp();
        chk("bp_killed_valid", 32'(inst_valid), 0); chk("bp_killed_rdata", inst_rdata, 32'h0050_0093);
        rd_fix = 32'h1234_5678;
        tick(); tick(); samp(); chk("bp_refetch_addr", bus_addr, 32'h500);
        tick(); tick(); samp(); chk("bp_refetch_valid", 32'(inst_valid), 1);
        chk("bp_refetch_rdata", inst_rdata, 32'h1234_5678);
        tick(); inst_req = 0;

        // store
        rd_fix = 32'hCAFE_F00D;
        data_req = 1; data_we = 1; data_addr = 32'h3000; data_wdata = 32'hDEAD_BEEF; data_op = 3'b010;
        samp();
        tick(); samp();
        chk("st_we", 32'(bus_we), 1); chk("st_addr", bus_addr, 32'h3000);
        chk("st_wdata", bus_wdata, 32'hDEAD_BEEF); chk("st_op", 32'(bus_op), 2);
        tick(); tick(); samp();
        chk("st_dvalid", 32'(data_valid), 1); chk("st_rdata_kept", data_rdata, 32'h0050_0093);
        tick(); data_req = 0; data_we = 0;

        // reset during WAIT_RSP
        rv_pct = 0;
        inst_req = 1; inst_addr = 32'h600;
        tick(); tick(); samp(); chk("rm_wait_breq", 32'(bus_req), 0);
        tick(); reset_n = 0; inst_req = 0;
        #1;
        chk("rm_breq", 32'(bus_req), 0); chk("rm_valids", 32'({inst_valid, data_valid}), 0);
        chk("rm_inst_rdata", inst_rdata, 0); chk("rm_data_rdata", data_rdata, 0);
        chk("rm_stalls", 32'({inst_stall, data_stall}), 0);
        tick(); reset_n = 1; rv_pct = 100;
        samp(); chk("rm_stray_breq", 32'(bus_req), 0);
        tick(); samp(); chk("rm_stray_valid", 32'({inst_valid, data_valid}), 0);
        tick(); inst_req = 1; inst_addr = 32'h700; rd_fix = 32'h0000_0013;
        samp();
        tick(); samp(); chk("rm_fresh_addr", bus_addr, 32'h700);
        tick(); tick(); samp(); chk("rm_fresh_valid", 32'(inst_valid), 1);
        tick(); inst_req = 0;

        // randomized traffic
        gnt_pct = 60; rv_pct = 40; rd_fix_en = 0;
        for (int c = 0; c < 3000; c++) begin
            samp();
            iv = inst_valid;
            dv = data_valid;
            tick();
            if (!inst_req || iv || inst_kill) begin
                inst_req = $urandom_range(99) < 60;
                inst_addr = $urandom & 32'hFFFF_FFFC;
            end
            inst_kill = inst_req && ($urandom_range(99) < 8);
            if (!data_req || dv) begin
                data_req = $urandom_range(99) < 60;
                data_we = 1'($urandom_range(1));
                data_addr = $urandom;
                data_wdata = $urandom;
                data_op = 3'($urandom_range(7));
            end
        end
        samp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
